// File: rtl/spi_arb_pkg.sv
`default_nettype none
// ============================================================================
// Module   : spi_arb_pkg
// Brief    : Shared types, field widths and helpers for the SPI request
//            arbiter (state encoding, command/length widths, one-hot decode).
// Revision : 1.0  initial release
// ============================================================================
package spi_arb_pkg;

  // Field widths of the SPI core request interface
  localparam int CMD_W = 8;
  localparam int LEN_W = 24;

  // Arbiter FSM states, explicitly encoded on two bits
  typedef enum logic [1:0] {
    IDLE      = 2'd0,
    WAIT_BUSY = 2'd1,
    EXEC      = 2'd2,
    RELEASE   = 2'd3
  } ARB_STATE;

  // Index of the set bit of a one-hot vector (up to 8 requesters); 0 for all-zero
  function automatic logic [2:0] onehot2idx(input logic [7:0] oh);
    logic [2:0] idx;
    idx = 3'd0;
    for (int i = 0; i < 8; i++) begin
      if (oh[i]) begin
        idx = idx | 3'(i);
      end
    end
    return idx;
  endfunction

endpackage : spi_arb_pkg
`default_nettype wire

// File: rtl/spi_rr_pick.sv
`default_nettype none
// ============================================================================
// Module   : spi_rr_pick
// Brief    : Combinational round-robin picker. Returns the one-hot position
//            of the first set request at or after ptr, wrapping cyclically.
// Revision : 1.0  initial release
// ============================================================================
module spi_rr_pick #(
  parameter int NUM   = 4,
  parameter int PTR_W = 2
) (
  input  logic [NUM-1:0]   req,
  input  logic [PTR_W-1:0] ptr,
  output logic [NUM-1:0]   gnt
);

  // Walk the requesters starting at ptr and keep only the first hit
  always_comb begin
    logic             w_found;
    logic [PTR_W-1:0] w_idx;
    gnt     = '0;
    w_found = 1'b0;
    w_idx   = '0;
    for (int k = 0; k < NUM; k++) begin
      w_idx = PTR_W'((int'(ptr) + k) % NUM);
      if (!w_found && req[w_idx]) begin
        gnt[w_idx] = 1'b1;
        w_found    = 1'b1;
      end
    end
  end

endmodule : spi_rr_pick
`default_nettype wire

// File: rtl/spi_req_arbiter.sv
`default_nettype none
// ============================================================================
// Module   : spi_req_arbiter
// Brief    : Round-robin arbiter sharing one SPI flash core request port
//            among NUM function modules. Holds one grant per transfer,
//            forwards the winner's request fields and write stream, and
//            returns core status/read strobes to the winner only.
//            Optional build macro SPI_ARB_TIMEOUT_EN: abort a granted request
//            when the core does not raise busy within TIMEOUT cycles and
//            pulse arb_err.
// Revision : 1.0  initial release
// ============================================================================
module spi_req_arbiter
  import spi_arb_pkg::*;
#(
  parameter int NUM     = 4,
  parameter int DSIZE   = 8,
  parameter int TIMEOUT = 1024
) (
  input  logic                   clock,
  input  logic                   rst_n,
  // requester side
  input  logic [NUM-1:0]         s_request,
  input  logic [NUM*CMD_W-1:0]   s_req_cmd,
  input  logic [NUM*LEN_W-1:0]   s_req_len,
  input  logic [NUM*LEN_W-1:0]   s_req_wr_len,
  input  logic [NUM-1:0]         s_wr_vld,
  input  logic [NUM*DSIZE-1:0]   s_wr_data,
  output logic [NUM-1:0]         s_busy,
  output logic [NUM-1:0]         s_wr_ready,
  output logic [NUM-1:0]         s_clk_en,
  output logic [NUM-1:0]         s_rd_vld,
  output logic [DSIZE-1:0]       s_rd_data,
  // core side
  output logic                   m_request,
  output logic [CMD_W-1:0]       m_req_cmd,
  output logic [LEN_W-1:0]       m_req_len,
  output logic [LEN_W-1:0]       m_req_wr_len,
  output logic                   m_wr_vld,
  output logic [DSIZE-1:0]       m_wr_data,
  input  logic                   m_busy,
  input  logic                   m_wr_ready,
  input  logic                   m_clk_en,
  input  logic                   m_rd_vld,
  input  logic [DSIZE-1:0]       m_rd_data,
  // status
  output logic [NUM-1:0]         grant,
  output logic                   arb_err
);

  localparam int PTR_W = (NUM > 1) ? $clog2(NUM) : 1;

  ARB_STATE         r_state;
  logic [NUM-1:0]   r_grant;
  logic [PTR_W-1:0] r_ptr;
  logic             r_m_request;
  logic             r_arb_err;

  logic [NUM-1:0]   w_pick;
  logic             w_req_g;
  logic [7:0]       w_grant8;
  logic [2:0]       w_gidx;
  logic [PTR_W-1:0] w_next_ptr;

`ifdef SPI_ARB_TIMEOUT_EN
  localparam int               CNT_W      = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;
  localparam logic [CNT_W-1:0] C_CNT_LAST = CNT_W'(TIMEOUT - 1);
  logic [CNT_W-1:0] r_cnt;
`else
  // TIMEOUT only matters when the watchdog is built in
  logic w_unused_timeout;
  assign w_unused_timeout = (TIMEOUT > 0);
`endif

  spi_rr_pick #(
    .NUM   (NUM),
    .PTR_W (PTR_W)
  ) u_pick (
    .req (s_request),
    .ptr (r_ptr),
    .gnt (w_pick)
  );

  // Request level of the currently granted requester, and the slot after it
  assign w_req_g    = |(s_request & r_grant);
  assign w_grant8   = 8'(r_grant);
  assign w_gidx     = onehot2idx(w_grant8);
  assign w_next_ptr = (w_gidx == 3'(NUM - 1)) ? '0 : PTR_W'(w_gidx + 3'd1);

  // Arbitration FSM: latch a grant in IDLE, hold it until the core finishes
  always_ff @(posedge clock or negedge rst_n) begin
    if (!rst_n) begin
      r_state     <= IDLE;
      r_grant     <= '0;
      r_ptr       <= '0;
      r_m_request <= 1'b0;
      r_arb_err   <= 1'b0;
`ifdef SPI_ARB_TIMEOUT_EN
      r_cnt       <= '0;
`endif
    end else begin
      r_arb_err <= 1'b0;
`ifdef SPI_ARB_TIMEOUT_EN
      r_cnt     <= '0;
`endif
      case (r_state)
        IDLE: begin
          r_m_request <= 1'b0;
          if (|s_request) begin
            r_grant <= w_pick;
            r_state <= WAIT_BUSY;
          end
        end
        WAIT_BUSY: begin
          if (m_busy) begin
            r_m_request <= 1'b0;
            r_state     <= EXEC;
          end else if (!w_req_g) begin
            // requester withdrew before the core accepted: abort
            r_m_request <= 1'b0;
            r_state     <= RELEASE;
`ifdef SPI_ARB_TIMEOUT_EN
          end else if (r_cnt == C_CNT_LAST) begin
            r_m_request <= 1'b0;
            r_arb_err   <= 1'b1;
            r_state     <= RELEASE;
          end else begin
            r_m_request <= 1'b1;
            r_cnt       <= r_cnt + 1'b1;
          end
`else
          end else begin
            r_m_request <= 1'b1;
          end
`endif
        end
        EXEC: begin
          r_m_request <= 1'b0;
          if (!m_busy) begin
            r_state <= RELEASE;
          end
        end
        RELEASE: begin
          r_m_request <= 1'b0;
          r_grant     <= '0;
          r_ptr       <= w_next_ptr;
          r_state     <= IDLE;
        end
        default: begin
          r_m_request <= 1'b0;
          r_grant     <= '0;
          r_state     <= IDLE;
        end
      endcase
    end
  end

  // Forward the granted requester's fields; all-zero when nobody holds the grant
  always_comb begin
    m_req_cmd    = '0;
    m_req_len    = '0;
    m_req_wr_len = '0;
    m_wr_data    = '0;
    for (int i = 0; i < NUM; i++) begin
      if (r_grant[i]) begin
        m_req_cmd    = m_req_cmd    | s_req_cmd[i*CMD_W +: CMD_W];
        m_req_len    = m_req_len    | s_req_len[i*LEN_W +: LEN_W];
        m_req_wr_len = m_req_wr_len | s_req_wr_len[i*LEN_W +: LEN_W];
        m_wr_data    = m_wr_data    | s_wr_data[i*DSIZE +: DSIZE];
      end
    end
  end

  // Status back to requesters is a single AND with the grant bit
  assign m_wr_vld   = |(s_wr_vld & r_grant);
  assign s_busy     = r_grant & {NUM{m_busy}};
  assign s_wr_ready = r_grant & {NUM{m_wr_ready}};
  assign s_clk_en   = r_grant & {NUM{m_clk_en}};
  assign s_rd_vld   = r_grant & {NUM{m_rd_vld}};
  assign s_rd_data  = m_rd_data;

  assign m_request  = r_m_request;
  assign grant      = r_grant;
  assign arb_err    = r_arb_err;

endmodule : spi_req_arbiter
`default_nettype wire

// File: tb/tb_spi_req_arbiter.sv
`default_nettype none
// ============================================================================
// Module   : tb_spi_req_arbiter
// Brief    : Directed self-checking bench for spi_req_arbiter (NUM=4,
//            DSIZE=8, TIMEOUT=16). Timeout behaviour follows the
//            SPI_ARB_TIMEOUT_EN macro.
// Revision : 1.0  initial release
// ============================================================================
module tb_spi_req_arbiter;

  localparam int NUM   = 4;
  localparam int DSIZE = 8;

  logic              clock;
  logic              rst_n;
  logic [NUM-1:0]    s_request;
  logic [NUM*8-1:0]  s_req_cmd;
  logic [NUM*24-1:0] s_req_len;
  logic [NUM*24-1:0] s_req_wr_len;
  logic [NUM-1:0]    s_wr_vld;
  logic [NUM*8-1:0]  s_wr_data;
  logic [NUM-1:0]    s_busy;
  logic [NUM-1:0]    s_wr_ready;
  logic [NUM-1:0]    s_clk_en;
  logic [NUM-1:0]    s_rd_vld;
  logic [7:0]        s_rd_data;
  logic              m_request;
  logic [7:0]        m_req_cmd;
  logic [23:0]       m_req_len;
  logic [23:0]       m_req_wr_len;
  logic              m_wr_vld;
  logic [7:0]        m_wr_data;
  logic              m_busy;
  logic              m_wr_ready;
  logic              m_clk_en;
  logic              m_rd_vld;
  logic [7:0]        m_rd_data;
  logic [NUM-1:0]    grant;
  logic              arb_err;

  int n_checks = 0;
  int n_errors = 0;

  spi_req_arbiter #(
    .NUM     (NUM),
    .DSIZE   (DSIZE),
    .TIMEOUT (16)
  ) dut (
    .clock        (clock),
    .rst_n        (rst_n),
    .s_request    (s_request),
    .s_req_cmd    (s_req_cmd),
    .s_req_len    (s_req_len),
    .s_req_wr_len (s_req_wr_len),
    .s_wr_vld     (s_wr_vld),
    .s_wr_data    (s_wr_data),
    .s_busy       (s_busy),
    .s_wr_ready   (s_wr_ready),
    .s_clk_en     (s_clk_en),
    .s_rd_vld     (s_rd_vld),
    .s_rd_data    (s_rd_data),
    .m_request    (m_request),
    .m_req_cmd    (m_req_cmd),
    .m_req_len    (m_req_len),
    .m_req_wr_len (m_req_wr_len),
    .m_wr_vld     (m_wr_vld),
    .m_wr_data    (m_wr_data),
    .m_busy       (m_busy),
    .m_wr_ready   (m_wr_ready),
    .m_clk_en     (m_clk_en),
    .m_rd_vld     (m_rd_vld),
    .m_rd_data    (m_rd_data),
    .grant        (grant),
    .arb_err      (arb_err)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  // Hard stop in case something stalls the sequence
  initial begin
    #200000;
    $display("FAIL watchdog: simulation still running at %0t, required finish earlier", $time);
    $fatal(1);
  end

  task automatic check_val(input string tag, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", tag, act, exp, $time);
    end
  endtask

  // Advance to the next falling edge, where outputs are sampled and inputs change
  task automatic tick();
    @(negedge clock);
  endtask

  // Wait (bounded) for a grant, then run a full transfer with busy_n busy cycles
  task automatic do_xfer(input logic [3:0] exp_g, input int busy_n);
    int n;
    n = 0;
    while (grant == '0 && n < 6) begin
      tick();
      n++;
    end
    check_val("xfer_grant", grant, exp_g);
    check_val("xfer_mreq_lat1", m_request, 0);
    tick();
    check_val("xfer_mreq", m_request, 1);
    m_busy = 1'b1;
    tick();
    check_val("xfer_s_busy", s_busy, exp_g);
    check_val("xfer_mreq_exec", m_request, 0);
    repeat (busy_n - 1) tick();
    m_busy = 1'b0;
    tick();
    check_val("xfer_release_hold", grant, exp_g);
    tick();
    check_val("xfer_idle_gap", grant, 0);
  endtask

  initial begin
    rst_n      = 1'b0;
    s_request  = '0;
    s_wr_vld   = '0;
    m_busy     = 1'b0;
    m_wr_ready = 1'b0;
    m_clk_en   = 1'b0;
    m_rd_vld   = 1'b0;
    m_rd_data  = 8'h00;
    for (int i = 0; i < NUM; i++) begin
      s_req_cmd[i*8 +: 8]     = 8'h10 + 8'(i);
      s_req_len[i*24 +: 24]   = 24'h000100 + 24'(i);
      s_req_wr_len[i*24 +: 24]= 24'h000200 + 24'(i);
      s_wr_data[i*8 +: 8]     = 8'h50 + 8'(i);
    end

    // ---- reset state ----
    tick();
    tick();
    check_val("rst_grant", grant, 0);
    check_val("rst_mreq", m_request, 0);
    check_val("rst_err", arb_err, 0);
    check_val("rst_cmd", m_req_cmd, 0);
    check_val("rst_ptr", dut.r_ptr, 0);
    rst_n = 1'b1;

    // ---- single requester 2 ----
    s_request = 4'b0100;
    tick();
    check_val("single_grant", grant, 4'b0100);
    check_val("single_cmd", m_req_cmd, 8'h12);
    check_val("single_len", m_req_len, 24'h000102);
    check_val("single_mreq0", m_request, 0);
    tick();
    check_val("single_mreq1", m_request, 1);
    m_busy = 1'b1;
    tick();
    check_val("single_s_busy", s_busy, 4'b0100);
    repeat (9) tick();
    m_busy    = 1'b0;
    s_request = 4'b0000;
    tick();
    check_val("single_release", grant, 4'b0100);
    tick();
    check_val("single_idle", grant, 0);
    check_val("single_ptr", dut.r_ptr, 3);

    // ---- reset pulse restores pointer ----
    rst_n = 1'b0;
    #1;
    check_val("rstp_grant", grant, 0);
    check_val("rstp_ptr", dut.r_ptr, 0);
    tick();
    rst_n = 1'b1;

    // ---- all four requesting: rotation 0,1,2,3,0 ----
    s_request = 4'b1111;
    do_xfer(4'b0001, 3);
    do_xfer(4'b0010, 3);
    do_xfer(4'b0100, 3);
    do_xfer(4'b1000, 3);
    do_xfer(4'b0001, 3);
    s_request = 4'b0000;
    check_val("rr_ptr", dut.r_ptr, 1);

    // ---- isolation: 1 granted while 3 drives write data ----
    s_request                = 4'b1010;
    s_wr_vld                 = 4'b1010;
    s_wr_data[3*8 +: 8]      = 8'hAA;
    m_wr_ready               = 1'b1;
    m_clk_en                 = 1'b1;
    m_rd_vld                 = 1'b1;
    m_rd_data                = 8'h3C;
    tick();
    check_val("iso_grant", grant, 4'b0010);
    check_val("iso_wr_data", m_wr_data, 8'h51);
    check_val("iso_wr_vld", m_wr_vld, 1);
    check_val("iso_cmd", m_req_cmd, 8'h11);
    check_val("iso_wr_len", m_req_wr_len, 24'h000201);
    check_val("iso_wr_ready", s_wr_ready, 4'b0010);
    check_val("iso_clk_en", s_clk_en, 4'b0010);
    check_val("iso_rd_vld", s_rd_vld, 4'b0010);
    check_val("iso_rd_data", s_rd_data, 8'h3C);
    tick();
    check_val("iso_mreq", m_request, 1);
    // requester 1 withdraws in WAIT_BUSY; 3 keeps waiting
    s_request = 4'b1000;
    tick();
    check_val("iso_abort_rel", grant, 4'b0010);
    check_val("iso_abort_mreq", m_request, 0);
    tick();
    check_val("iso_abort_idle", grant, 0);
    check_val("iso_abort_ptr", dut.r_ptr, 2);
    tick();
    check_val("iso_next_grant", grant, 4'b1000);
    check_val("iso_wr_data3", m_wr_data, 8'hAA);
    s_request = 4'b0000;
    tick();
    check_val("iso3_release", grant, 4'b1000);
    check_val("iso3_mreq", m_request, 0);
    tick();
    check_val("iso3_ptr", dut.r_ptr, 0);
    s_wr_vld   = '0;
    m_wr_ready = 1'b0;
    m_clk_en   = 1'b0;
    m_rd_vld   = 1'b0;

    // ---- abort by requester 0 ----
    s_request = 4'b0001;
    tick();
    check_val("abort_grant", grant, 4'b0001);
    tick();
    check_val("abort_mreq1", m_request, 1);
    s_request = 4'b0000;
    tick();
    check_val("abort_release", grant, 4'b0001);
    check_val("abort_mreq0", m_request, 0);
    tick();
    check_val("abort_idle", grant, 0);
    check_val("abort_ptr", dut.r_ptr, 1);

    // ---- core never raises busy ----
    s_request = 4'b0010;
    tick();
    check_val("to_grant", grant, 4'b0010);
`ifdef SPI_ARB_TIMEOUT_EN
    repeat (15) tick();
    check_val("to_err_early", arb_err, 0);
    check_val("to_mreq_hold", m_request, 1);
    tick();
    check_val("to_err_pulse", arb_err, 1);
    check_val("to_mreq_drop", m_request, 0);
    check_val("to_release", grant, 4'b0010);
    s_request = 4'b0000;
    tick();
    check_val("to_err_clear", arb_err, 0);
    check_val("to_idle", grant, 0);
    check_val("to_ptr", dut.r_ptr, 2);
`else
    repeat (20) tick();
    check_val("noto_err", arb_err, 0);
    check_val("noto_grant_hold", grant, 4'b0010);
    check_val("noto_mreq_hold", m_request, 1);
    s_request = 4'b0000;
    tick();
    check_val("noto_release", grant, 4'b0010);
    tick();
    check_val("noto_idle", grant, 0);
    check_val("noto_ptr", dut.r_ptr, 2);
`endif

    // ---- asynchronous reset during EXEC ----
    s_request = 4'b0100;
    tick();
    check_val("rx_grant", grant, 4'b0100);
    tick();
    m_busy     = 1'b1;
    tick();
    m_wr_ready = 1'b1;
    m_clk_en   = 1'b1;
    m_rd_vld   = 1'b1;
    #1;
    check_val("rx_s_busy", s_busy, 4'b0100);
    check_val("rx_s_clk_en", s_clk_en, 4'b0100);
    #1;
    rst_n = 1'b0;
    #1;
    check_val("rx_grant0", grant, 0);
    check_val("rx_mreq0", m_request, 0);
    check_val("rx_s_busy0", s_busy, 0);
    check_val("rx_s_wr_ready0", s_wr_ready, 0);
    check_val("rx_s_clk_en0", s_clk_en, 0);
    check_val("rx_s_rd_vld0", s_rd_vld, 0);
    check_val("rx_cmd0", m_req_cmd, 0);
    s_request  = 4'b0000;
    m_busy     = 1'b0;
    m_wr_ready = 1'b0;
    m_clk_en   = 1'b0;
    m_rd_vld   = 1'b0;
    tick();
    rst_n = 1'b1;
    tick();

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule : tb_spi_req_arbiter
`default_nettype wire

// File: doc/spi_req_arbiter.md
# spi_req_arbiter

Round-robin arbiter that shares one SPI flash core request port among up to NUM function modules (write enable/disable, read, page program, erase, status). Each function module is a requester. The arbiter latches one grant, forwards that requester's request, length, command and write stream to the core, and returns the core's busy, ready and read stream to the granted requester only. It sits between the function-module bank and the SPI core. It releases the grant when the core's busy falls.

## Interface
Parameters:
- NUM, 4, number of requesters (2..8)
- DSIZE, 8, write/read data width
- TIMEOUT, 1024, cycles to wait for core busy after forwarding a request (used only with SPI_ARB_TIMEOUT_EN)

Ports (index i = requester; flattened arrays use slot i at [i*W +: W]):
- clock  in  1  single clock
- rst_n  in  1  asynchronous active-low reset
- s_request  in  NUM  per-requester request level
- s_req_cmd  in  NUM*8  per-requester command
- s_req_len  in  NUM*24  total transfer length
- s_req_wr_len  in  NUM*24  write-phase length
- s_wr_vld  in  NUM  write data valid
- s_wr_data  in  NUM*DSIZE  write data
- s_busy  out  NUM  core busy, routed to the granted requester only
- s_wr_ready  out  NUM  core wr_ready, gated by grant
- s_clk_en  out  NUM  core clk_en, gated by grant
- s_rd_vld  out  NUM  core rd_vld, gated by grant
- s_rd_data  out  DSIZE  core rd_data, broadcast to all requesters
- m_request  out  1  request to core
- m_req_cmd, m_req_len, m_req_wr_len, m_wr_vld, m_wr_data  out  8/24/24/1/DSIZE  granted requester's fields; 0 when there is no grant
- m_busy, m_wr_ready, m_clk_en, m_rd_vld  in  1  core status
- m_rd_data  in  DSIZE  core read data
- grant  out  NUM  one-hot current grant; 0 when idle
- arb_err  out  1  one-cycle timeout pulse (0 without the macro)

## Operation
- FSM states: IDLE, WAIT_BUSY, EXEC, RELEASE.
- IDLE: if any s_request is set, pick the first set bit at or after pointer ptr, cyclically. Register the one-hot grant, then go to WAIT_BUSY.
- WAIT_BUSY: m_request = s_request[g] (registered). On m_busy=1, go to EXEC. If s_request[g] drops before m_busy, go to RELEASE (abort).
- EXEC: m_request = 0. On m_busy=0, go to RELEASE.
- RELEASE: one cycle with the grant still held. Then grant is cleared and ptr = (g+1) mod NUM. Next state is IDLE.
- Muxes from the grant register are combinational: m_req_*, m_wr_*, and all s_* returns.
- A non-granted requester sees s_busy=0, s_wr_ready=0, s_clk_en=0 and s_rd_vld=0. It keeps requesting until it is served.
- Reset values: grant=0, ptr=0, m_request=0, state IDLE, arb_err=0. All muxed outputs are therefore 0.
- Reset mid-transfer: the grant is dropped at once. The core is expected to be reset by the same rst_n.

## Timing
- Request-to-core latency is 2 cycles: s_request is sampled in IDLE at cycle n, grant is valid at n+1, m_request is set at n+2.
- m_busy falling at cycle k: RELEASE at k+1, IDLE at k+2. The earliest next grant is at k+3.
- The grant never changes outside IDLE, whatever happens on s_request.
- Simultaneous requests: rotation order from ptr. After reset, requester 0 wins ties.
- A requester that holds s_request through RELEASE is not re-granted until the others have been served (fairness: at most NUM-1 grants in between).
- The combinational path from m_wr_ready/m_clk_en to s_* is a single AND with the grant bit.

## Configuration
- SPI_ARB_TIMEOUT_EN defined: a counter runs in WAIT_BUSY. If it reaches TIMEOUT-1 without m_busy, then:
  - arb_err pulses for 1 cycle;
  - m_request is dropped;
  - the FSM goes to RELEASE and ptr advances.
- The counter is cleared on every state entry. Width is $clog2(TIMEOUT).
- Not defined: no counter, arb_err is tied to 0, and WAIT_BUSY waits indefinitely.

## Structure
- Package spi_arb_pkg holds:
  - the ARB_STATE enum {IDLE, WAIT_BUSY, EXEC, RELEASE};
  - localparams LEN_W=24 and CMD_W=8;
  - the function onehot2idx.
- Sub-module spi_rr_pick: combinational round-robin priority picker with inputs req[NUM] and ptr, output one-hot gnt[NUM].

## Test plan
- Single requester: s_request[2]=1 after reset, core busy high for 10 cycles. Expect:
  - grant=4'b0100 one cycle later, m_request one cycle after that;
  - RELEASE after busy falls, then grant=0, ptr=3.
- Simultaneous requests: s_request=4'b1111 held. Expect grants in order 0,1,2,3,0, with no grant during the RELEASE/IDLE gaps.
- Isolation: while 1 is granted, requester 3 asserts s_wr_vld and s_wr_data=8'hAA. Expect m_wr_data to carry only 1's data and s_wr_ready[3] to stay 0.
- Abort: requester 0 drops s_request in WAIT_BUSY before m_busy. Expect RELEASE, m_request=0, and ptr=1.
- Timeout (SPI_ARB_TIMEOUT_EN, TIMEOUT=16): m_busy is held 0. Expect arb_err to pulse 16 cycles after WAIT_BUSY entry and the grant to be released.
- Reset mid-EXEC: assert rst_n=0. Expect grant, m_request and all s_* to be 0 immediately, with asynchronous effect.
